// File: rtl/bcd_score_keeper.sv
// Dino game score keeper: 4-digit packed-BCD running score and high score,
// with a small IDLE/RUN/OVER game-state FSM and a digit-milestone pulse.
module bcd_score_keeper #(
  parameter logic [15:0] HI_INIT         = 16'h0000,
  parameter int unsigned MILESTONE_DIGIT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_die,
  input  logic        i_tick,
  input  logic [15:0] i_step,
  output logic [15:0] o_score,
  output logic [15:0] o_hi_score,
  output logic [1:0]  o_state,
  output logic        o_milestone,
  output logic        o_maxed
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  localparam int unsigned MS_SHIFT = 4 * MILESTONE_DIGIT;

  logic [1:0]  r_state;
  logic [15:0] r_score;
  logic [15:0] r_hi;
  logic        r_milestone;
  logic        r_maxed;

  logic [3:0]  w_nib;
  logic [4:0]  w_dsum;
  logic [4:0]  w_carry;
  logic [15:0] w_sum;
  logic [15:0] w_next;
  logic        w_ms;
  logic        w_sat;

  // Decimal ripple add; step nibbles above 9 are treated as 9.
  always_comb begin
    w_nib   = '0;
    w_dsum  = '0;
    w_carry = '0;
    w_sum   = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      w_nib = i_step[4*d +: 4];
      if (w_nib > 4'd9) begin
        w_nib = 4'd9;
      end
      w_dsum = {1'b0, r_score[4*d +: 4]} + {1'b0, w_nib} + {4'b0000, w_carry[d]};
      if (w_dsum > 5'd9) begin
        w_sum[4*d +: 4] = w_dsum[3:0] + 4'd6;
        w_carry[d+1]    = 1'b1;
      end else begin
        w_sum[4*d +: 4] = w_dsum[3:0];
      end
    end
    w_next = w_carry[4] ? 16'h9999 : w_sum;
    w_sat  = (w_next == 16'h9999);
    w_ms   = (w_next >> MS_SHIFT) > (r_score >> MS_SHIFT);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_score     <= '0;
      r_hi        <= HI_INIT;
      r_milestone <= 1'b0;
      r_maxed     <= 1'b0;
    end else begin
      r_milestone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_score <= '0;
            r_maxed <= 1'b0;
          end
        end
        ST_RUN: begin
          // Commit uses the pre-edge score regardless of a coincident start.
          if (i_die && (r_score > r_hi)) begin
            r_hi <= r_score;
          end
          if (i_start) begin
            r_score <= '0;
            r_maxed <= 1'b0;
          end else if (i_die) begin
            r_state <= ST_OVER;
          end else if (i_tick) begin
            r_score     <= w_next;
            r_maxed     <= w_sat;
            r_milestone <= w_ms;
          end
        end
        ST_OVER: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_score <= '0;
            r_maxed <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_score     = r_score;
  assign o_hi_score  = r_hi;
  assign o_state     = r_state;
  assign o_milestone = r_milestone;
  assign o_maxed     = r_maxed;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Directed test of bcd_score_keeper with hand-computed expected values.
module tb_bcd_score_keeper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        die = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] step = 16'h0000;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic [1:0]  state;
  logic        milestone;
  logic        maxed;

  int total = 0;
  int bad   = 0;

  bcd_score_keeper #(
    .HI_INIT        (16'h0000),
    .MILESTONE_DIGIT(2)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_die      (die),
    .i_tick     (tick),
    .i_step     (step),
    .o_score    (score),
    .o_hi_score (hi_score),
    .o_state    (state),
    .o_milestone(milestone),
    .o_maxed    (maxed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_score, input logic [15:0] e_hi,
                         input logic [1:0] e_state, input logic e_ms, input logic e_max);
    chk({tag, ".score"}, score, e_score);
    chk({tag, ".hi"}, hi_score, e_hi);
    chk({tag, ".state"}, {14'd0, state}, {14'd0, e_state});
    chk({tag, ".milestone"}, {15'd0, milestone}, {15'd0, e_ms});
    chk({tag, ".maxed"}, {15'd0, maxed}, {15'd0, e_max});
  endtask

  // Drive one cycle of pulses, then sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic s, input logic d, input logic t, input logic [15:0] st);
    rst = r; start = s; die = d; tick = t; step = st;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; die = 1'b0; tick = 1'b0; step = 16'h0000;
  endtask

  initial begin
    #2;
    // reset and idle behaviour
    cyc(1, 0, 0, 0, 16'h0000);
    chk_all("reset", 16'h0000, 16'h0000, 2'b00, 0, 0);
    cyc(0, 0, 1, 1, 16'h0001);
    chk_all("idle_ignore", 16'h0000, 16'h0000, 2'b00, 0, 0);

    // basic count
    cyc(0, 1, 0, 0, 16'h0000);
    chk_all("start1", 16'h0000, 16'h0000, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0001);
    chk_all("cnt1", 16'h0001, 16'h0000, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0001);
    chk_all("cnt2", 16'h0002, 16'h0000, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0001);
    chk_all("cnt3", 16'h0003, 16'h0000, 2'b01, 0, 0);

    // carry and milestone
    cyc(0, 1, 0, 0, 16'h0000);
    chk("carry.clear", score, 16'h0000);
    cyc(0, 0, 0, 1, 16'h0099);
    chk_all("pre99", 16'h0099, 16'h0000, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0001);
    chk_all("to100", 16'h0100, 16'h0000, 2'b01, 1, 0);
    cyc(0, 0, 0, 0, 16'h0000);
    chk_all("ms_one_cycle", 16'h0100, 16'h0000, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0001);
    chk_all("to101", 16'h0101, 16'h0000, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0000);
    chk_all("step0", 16'h0101, 16'h0000, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0909);
    chk_all("multi_carry", 16'h1010, 16'h0000, 2'b01, 1, 0);

    // saturation
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 1, 16'h9990);
    chk_all("to9990", 16'h9990, 16'h0000, 2'b01, 1, 0);
    cyc(0, 0, 0, 1, 16'h0015);
    chk_all("sat", 16'h9999, 16'h0000, 2'b01, 0, 1);
    cyc(0, 0, 0, 1, 16'h0001);
    chk_all("sat_hold", 16'h9999, 16'h0000, 2'b01, 0, 1);
    cyc(0, 1, 0, 0, 16'h0000);
    chk_all("sat_clear", 16'h0000, 16'h0000, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h9890);
    chk_all("to9890", 16'h9890, 16'h0000, 2'b01, 1, 0);
    cyc(0, 0, 0, 1, 16'h0200);
    chk_all("sat_ms", 16'h9999, 16'h0000, 2'b01, 1, 1);

    // high score across games
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 1, 16'h0123);
    chk_all("g1_123", 16'h0123, 16'h0000, 2'b01, 1, 0);
    cyc(0, 0, 1, 0, 16'h0000);
    chk_all("g1_die", 16'h0123, 16'h0123, 2'b10, 0, 0);
    cyc(0, 0, 1, 1, 16'h0001);
    chk_all("over_ignore", 16'h0123, 16'h0123, 2'b10, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000);
    chk_all("g2_start", 16'h0000, 16'h0123, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0045);
    cyc(0, 0, 1, 0, 16'h0000);
    chk_all("g2_die", 16'h0045, 16'h0123, 2'b10, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 1, 16'h0500);
    cyc(0, 0, 1, 0, 16'h0000);
    chk_all("g3_die", 16'h0500, 16'h0500, 2'b10, 0, 0);

    // coincident pulses
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 1, 16'h0042);
    cyc(0, 0, 1, 1, 16'h0001);
    chk_all("die_tick", 16'h0042, 16'h0500, 2'b10, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 1, 16'h0077);
    cyc(0, 1, 1, 0, 16'h0000);
    chk_all("start_die_low", 16'h0000, 16'h0500, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0777);
    cyc(0, 1, 1, 0, 16'h0000);
    chk_all("start_die_high", 16'h0000, 16'h0777, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0005);
    cyc(0, 1, 0, 1, 16'h0001);
    chk_all("start_tick", 16'h0000, 16'h0777, 2'b01, 0, 0);

    // mid-game reset and clamped step nibbles
    cyc(0, 0, 0, 1, 16'h0300);
    chk("mid.pre", score, 16'h0300);
    cyc(1, 1, 1, 1, 16'h0001);
    chk_all("mid_reset", 16'h0000, 16'h0000, 2'b00, 0, 0);
    cyc(0, 1, 0, 0, 16'h0000);
    cyc(0, 0, 0, 1, 16'h000F);
    chk_all("clamp_F", 16'h0009, 16'h0000, 2'b01, 0, 0);
    cyc(0, 0, 0, 1, 16'h0A0B);
    chk_all("clamp_AB", 16'h0918, 16'h0000, 2'b01, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_score_keeper.md
Name: bcd_score_keeper

Overview:
- Keeps the Dino game's running score and high score as 4-digit packed BCD (digit 3 = thousands in [15:12], digit 0 = units in [3:0]).
- Sits upstream of the score display. Its per-tick update path is a 4-digit BCD add of the current score and a BCD step, followed by saturation and register.
- A small game-state FSM controls when the score counts, when it clears, and when the high score is committed.

Parameters:
- HI_INIT, 16'h0000, reset value of hi_score (packed BCD).
- MILESTONE_DIGIT, 2, index of the digit whose increment raises milestone (0=units … 3=thousands). 2 = every 100 points.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse: begin a new game.
- die  in  1  1-cycle pulse: player collided, game ends.
- tick  in  1  1-cycle pulse: score event (frame/distance tick).
- step  in  16  BCD increment applied per tick (normally 16'h0001).
- score  out  16  current score, packed BCD.
- hi_score  out  16  best score since reset, packed BCD.
- state  out  2  2'b00 IDLE, 2'b01 RUN, 2'b10 OVER.
- milestone  out  1  1-cycle pulse when a tick moves the score across a multiple of 10^MILESTONE_DIGIT.
- maxed  out  1  high while score is saturated at 9999.

Behaviour:
Reset (rst=1 at a clock edge, from any state, mid-game included):
- score=16'h0000, hi_score=HI_INIT, state=IDLE, milestone=0, maxed=0.
- rst overrides all other inputs that cycle.

FSM:
- IDLE: start → RUN, score cleared to 0000. tick and die are ignored.
- RUN:
  - tick → score updated.
  - die → OVER, high score committed.
  - start → score cleared to 0000, stay RUN; this is a restart with no hi commit.
- OVER: score held. start → RUN, score cleared. tick and die are ignored.

Priority in RUN when pulses coincide:
- die with start: hi commit occurs using the pre-edge score, score is cleared, next state is RUN.
- die with tick: the tick is dropped and the committed value is the pre-tick score.
- start with tick: the tick is dropped; score becomes 0000.

Score update (RUN and tick only):
- Latency: 1 cycle. score shows the new value on the edge following the tick-high cycle.
- Each step nibble > 9 is clamped to 9 before adding.
- Per-digit BCD add with decimal carry propagates from digit 0 to digit 3.
- If the carry out of digit 3 is 1, score becomes 16'h9999 and maxed is set.
- While score = 9999, maxed stays 1 and further ticks leave score unchanged.
- maxed clears only on rst or on the start clear.
- step = 0000 leaves score unchanged and produces no milestone.

Milestone:
- Pulses high for exactly one cycle, registered in the same edge as the new score.
- Condition: the new score's digits [3:MILESTONE_DIGIT] as a number exceed the old score's digits [3:MILESTONE_DIGIT].
- Also fires on the tick that saturates, if that condition holds.
- Never fires on clear, on no-change ticks, or outside RUN.

High-score commit:
- On die accepted in RUN: if score > hi_score then hi_score ← score, effective the next cycle.
- Packed-BCD comparison is equal to unsigned comparison of the 16-bit vectors.
- hi_score is otherwise constant and is never modified by start.

Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
- Reset and basic count: rst 1 cycle; start; 3 ticks with step=0001 → score 0001, 0002, 0003 each on the edge after its tick; state=01; milestone=0; hi_score=0000.
- Carry and milestone: start, preload via ticks step=0099, then tick step=0001 → score 0100 with milestone=1 for exactly one cycle. Next tick step=0001 → 0101, milestone=0.
- Saturation: from score 9990, tick step=0015 → 9999, maxed=1. Another tick → still 9999, no milestone. start → 0000, maxed=0.
- High score: game 1 dies at 0123 → state=10, hi_score=0123. Game 2 dies at 0045 → hi_score remains 0123. Game 3 dies at 0500 → hi_score=0500.
- Coincident pulses: in RUN at 0042, die+tick same cycle → score 0042, state OVER, hi_score ≥ 0042. In RUN at 0077, start+die → hi_score=max(old,0077), score 0000, state RUN.
- Mid-game reset and invalid step: in RUN at 0300 with hi 0500, rst → score 0000, hi_score=HI_INIT, state IDLE. Then start, tick with step=000F → score 0009.
